// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes/sign flags at launch, and
// two's-complement fixup of product, quotient and remainder on completion.
module muldiv_signfix #(
    parameter int W = muldiv_pkg::DEF_WIDTH
) (
    input  logic           signed_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   a_abs_o,
    output logic [W-1:0]   b_abs_o,
    output logic           a_neg_o,
    output logic           b_neg_o,
    input  logic           res_neg_i,
    input  logic           rem_neg_i,
    input  logic [2*W-1:0] prod_i,
    input  logic [W-1:0]   quot_i,
    input  logic [W-1:0]   rem_i,
    output logic [2*W-1:0] prod_o,
    output logic [W-1:0]   quot_o,
    output logic [W-1:0]   rem_o
);

    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    assign a_neg_o = signed_i & a_i[W-1];
    assign b_neg_o = signed_i & b_i[W-1];

    // The most negative value maps onto itself, which reads correctly as unsigned.
    assign a_abs_o = a_neg_o ? (~a_i + ONE_W) : a_i;
    assign b_abs_o = b_neg_o ? (~b_i + ONE_W) : b_i;

    assign prod_o = res_neg_i ? (~prod_i + ONE_2W) : prod_i;
    assign quot_o = res_neg_i ? (~quot_i + ONE_W)  : quot_i;
    assign rem_o  = rem_neg_i ? (~rem_i + ONE_W)   : rem_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: WIDTH RUN cycles after the start edge, then a one-cycle done.
// No backpressure: start is ignored unless IDLE; flushE aborts RUN without touching HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                res_neg_q, res_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                div0_q, div0_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    logic                is_div;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH-1:0]    sub_res;
    logic                rem_ge;
    logic [2*WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]    rem_step;

    logic [WIDTH-1:0]    a_abs, b_abs;
    logic                a_neg, b_neg;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quot_fix, rem_fix;

    assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Multiply: multiplier sits in acc[W-1:0] and shifts out LSB-first.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};

    // Divide: dividend shifts out of acc[W-1:0] MSB-first while quotient bits shift in.
    assign rem_sh  = {rem_q, acc_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, opnd_q};
    assign sub_res = rem_sh[WIDTH-1:0] - opnd_q;

    always_comb begin
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_step = rem_q;
        if (is_div) begin
            acc_step = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
            rem_step = rem_ge ? sub_res : rem_sh[WIDTH-1:0];
        end
    end

    muldiv_signfix #(.W(WIDTH)) u_signfix (
        .signed_i  (~op[0]),
        .a_i       (srcaE),
        .b_i       (srcbE),
        .a_abs_o   (a_abs),
        .b_abs_o   (b_abs),
        .a_neg_o   (a_neg),
        .b_neg_o   (b_neg),
        .res_neg_i (res_neg_q),
        .rem_neg_i (rem_neg_q),
        .prod_i    (acc_step),
        .quot_i    (acc_step[WIDTH-1:0]),
        .rem_i     (rem_step),
        .prod_o    (prod_fix),
        .quot_o    (quot_fix),
        .rem_o     (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !flushE) begin
                    state_d   = RUN;
                    op_d      = op_e'(op);
                    cnt_d     = CNT_LAST;
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    div0_d    = (srcbE == '0);
                    rem_d     = '0;
                    if (op[1]) begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                    end
                end
            end
            RUN: begin
                if (flushE) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    rem_d = rem_step;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        // Remainder of x/0 already equals x after sign restore; only the quotient is forced.
                        if (is_div) begin
                            hi_d = rem_fix;
                            lo_d = div0_q ? ALL_ONES : quot_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MULT;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a cycle-level reference model checked every cycle.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flushE;
    logic [1:0]  op;
    logic [31:0] srcaE, srcbE;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .flushE (flushE),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycle model: an accepted start yields 32 busy cycles then one done cycle.
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (flushE) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    {m_hi, m_lo} = m_pend;
                end
            end
        end else if (start && !flushE) begin
            m_busy = 1'b1;
            m_left = 32;
            m_pend = ref_result(op, srcaE, srcbE);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc done", {31'd0, done}, {31'd0, m_done});
            check("cyc hi", hi_out, m_hi);
            check("cyc lo", lo_out, m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; srcaE = a; srcbE = b; start = 1'b1;
    endtask

    // Called right after issue(); stops at the negedge where done is seen.
    task automatic wait_result(input string nm, input logic [31:0] eh, input logic [31:0] el, input int pulse_at);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b0;
        srcaE = $urandom;
        srcbE = $urandom;
        n = 1;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
            start = (n == pulse_at);
        end
        start = 1'b0;
        check({nm, " latency"}, n, 33);
        check({nm, " busy cycles"}, nb, 32);
        check({nm, " hi"}, hi_out, eh);
        check({nm, " lo"}, lo_out, el);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        issue(o, a, b);
        wait_result(nm, eh, el, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] r;
        bit seen_done;
        reset = 1'b1; start = 1'b0; flushE = 1'b0; op = 2'b00; srcaE = '0; srcbE = '0;

        r = ref_result(2'b00, 32'hFFFFFFFD, 32'd5);
        check("model mult", r[31:0], 32'hFFFFFFF1);
        r = ref_result(2'b10, 32'hFFFFFFF9, 32'd2);
        check("model div rem", r[63:32], 32'hFFFFFFFF);
        r = ref_result(2'b11, 32'd100, 32'd0);
        check("model divu0", r[63:32], 32'h64);

        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult -3x5",    2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div -7/2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div -7/-2",    2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3);
        run_op("divu 100/0",   2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
        run_op("div -5/0",     2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_op("mult 6x7",     2'b00, 32'd6,        32'd7,        32'd0,        32'd42);

        // Flush during cycle 10 of a DIVU.
        @(negedge clk);
        issue(2'b11, 32'd9, 32'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0;
        check("flush busy cycle 11", {31'd0, busy}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("flush no done", {31'd0, seen_done}, 32'd0);
        check("flush hi held", hi_out, 32'd0);
        check("flush lo held", lo_out, 32'd42);

        // start together with flushE in IDLE: flush wins.
        @(negedge clk);
        issue(2'b00, 32'd2, 32'd3);
        flushE = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flushE = 1'b0;
        check("start+flush busy", {31'd0, busy}, 32'd0);

        // Reset mid-run, then a start on the very next cycle.
        @(negedge clk);
        issue(2'b01, 32'hFFFFFFFF, 32'd2);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset hi", hi_out, 32'd0);
        check("midreset lo", lo_out, 32'd0);
        issue(2'b11, 32'd9, 32'd4);
        wait_result("divu 9/4 after reset", 32'd1, 32'd2, -1);

        // start pulsed mid-RUN (operands also scrambled) must not disturb the result.
        @(negedge clk);
        issue(2'b11, 32'd1000, 32'd7);
        wait_result("divu 1000/7 start in run", 32'd6, 32'd142, 12);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
